// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, binary index
// and a hold-time limit that forces a handoff when other requesters are waiting.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       En,
    input  logic [3:0] Req,
    output logic [3:0] Gnt,
    output logic [1:0] Gidx,
    output logic       Gvalid
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gidx_q, gidx_d;
    logic       gvalid_q, gvalid_d;
    logic       ready_q;
    logic [1:0] win_s;
    logic       revoke_s;

    // Scan downward so the lowest offset from ptr (highest priority) is written last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        win = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            win = req[idx] ? idx : win;
        end
        return win;
    endfunction

    function automatic logic [3:0] decode2to4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign win_s    = rr_pick(Req, ptr_q);
    assign revoke_s = (Req[gidx_q] == 1'b0) ||
                      ((cnt_q == HOLD_MAX) && ((Req & ~gnt_q) != 4'b0000));

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        gvalid_d = gvalid_q;
        case (state_q)
            IDLE: begin
                // ready_q delays the first grant by one edge after reset release.
                if (ready_q && En && (Req != 4'b0000)) begin
                    state_d  = BUSY;
                    gnt_d    = decode2to4(win_s);
                    gidx_d   = win_s;
                    gvalid_d = 1'b1;
                    cnt_d    = 8'd1;
                end else begin
                    gnt_d    = 4'b0000;
                    gvalid_d = 1'b0;
                end
            end
            BUSY: begin
                if (revoke_s) begin
                    state_d  = IDLE;
                    gnt_d    = 4'b0000;
                    gvalid_d = 1'b0;
                    ptr_d    = gidx_q + 2'd1;
                end else begin
                    cnt_d = (cnt_q >= HOLD_MAX) ? cnt_q : (cnt_q + 8'd1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = 4'b0000;
                gvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            cnt_q    <= 8'd0;
            gnt_q    <= 4'b0000;
            gidx_q   <= 2'd0;
            gvalid_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            gvalid_q <= gvalid_d;
            ready_q  <= 1'b1;
        end
    end

    assign Gnt    = gnt_q;
    assign Gidx   = gidx_q;
    assign Gvalid = gvalid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=4; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic       En;
    logic [3:0] Req;
    logic [3:0] Gnt;
    logic [1:0] Gidx;
    logic       Gvalid;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (En),
        .Req    (Req),
        .Gnt    (Gnt),
        .Gidx   (Gidx),
        .Gvalid (Gvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks_cnt++;
        if (obs !== expv) begin
            failures_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] i, input logic v);
        check_eq({tag, "_gnt"},    {4'b0000, Gnt},    {4'b0000, g});
        check_eq({tag, "_gidx"},   {6'b000000, Gidx}, {6'b000000, i});
        check_eq({tag, "_gvalid"}, {7'b0000000, Gvalid}, {7'b0000000, v});
    endtask

    task automatic check_gnt(input string tag, input logic [3:0] g);
        check_eq(tag, {4'b0000, Gnt}, {4'b0000, g});
    endtask

    initial begin
        logic [3:0] e;
        rst_n = 1'b0;
        En    = 1'b1;
        Req   = 4'b1111;

        // Reset values hold while rst_n is low, despite full requests.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_out("reset", 4'b0000, 2'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_out("post_rst_edge1", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        check_out("post_rst_edge2", 4'b0001, 2'd0, 1'b1);

        // Single request then release; pointer moves to 1.
        Req = 4'b0001;
        @(negedge clk);
        check_out("single_hold", 4'b0001, 2'd0, 1'b1);
        Req = 4'b0000;
        @(negedge clk);
        check_out("single_rel", 4'b0000, 2'd0, 1'b0);
        Req = 4'b0011;
        @(negedge clk);
        check_out("ptr_one", 4'b0010, 2'd1, 1'b1);
        Req = 4'b0000;
        @(negedge clk);
        check_gnt("ptr_one_rel", 4'b0000);

        // Reset pulse to bring ptr back to 0 before contention.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        Req = 4'b1111;

        // Full contention: 4 grant cycles per owner, one dead cycle between.
        for (int r = 0; r < 5; r++) begin
            e = 4'b0001 << (r % 4);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check_gnt("contend_gnt", e);
            end
            if (r < 4) begin
                @(negedge clk);
                check_gnt("contend_dead", 4'b0000);
            end
        end
        Req = 4'b0000;
        @(negedge clk);
        check_gnt("contend_rel", 4'b0000);

        // Lone holder keeps the grant indefinitely.
        Req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_gnt("lone_hold", 4'b0100);
        end
        Req = 4'b0000;
        @(negedge clk);
        check_out("lone_rel", 4'b0000, 2'd2, 1'b0);

        // Saturated counter: a new competitor forces an immediate revoke.
        Req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_gnt("sat_hold", 4'b0100);
        end
        Req = 4'b0101;
        @(negedge clk);
        check_gnt("sat_revoke", 4'b0000);
        @(negedge clk);
        check_out("sat_handoff", 4'b0001, 2'd0, 1'b1);

        // Enable gating from IDLE; ptr is 1 after releasing requester 0.
        Req = 4'b0000;
        En  = 1'b0;
        @(negedge clk);
        check_gnt("en_rel", 4'b0000);
        Req = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_gnt("en_off", 4'b0000);
        end
        En = 1'b1;
        @(negedge clk);
        check_out("en_on", 4'b0010, 2'd1, 1'b1);

        // Dropping En while granted does not revoke.
        En  = 1'b0;
        Req = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_gnt("en_drop_hold", 4'b0010);
        end
        Req = 4'b0000;
        @(negedge clk);
        check_out("en_drop_rel", 4'b0000, 2'd1, 1'b0);

        // Async reset mid-grant, then ptr restarts at 0.
        En  = 1'b1;
        Req = 4'b1000;
        @(negedge clk);
        check_out("pre_async", 4'b1000, 2'd3, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 4'b0000, 2'd0, 1'b0);
        #1 rst_n = 1'b1;
        Req = 4'b1001;
        @(negedge clk);
        check_gnt("after_async1", 4'b0000);
        @(negedge clk);
        check_out("after_async2", 4'b0001, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
